lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Parametrised successor to the fixed-resolution RGB LCD driver.
- Generates HS/VS/DE timing for any panel from parameters, with selectable sync polarity.
- Issues pixel requests (x/y) LEAD cycles ahead of DE so upstream pixel sources can be pipelined, and supplies an internal colour-bar test mode.
- Sits between the PLL-clocked pixel domain and the panel pins. It replaces the fixed driver in the LCD top-level.

Parameters:
- H_SYNC, 128, HS pulse width in pclk cycles (≥1)
- H_BACK, 88, horizontal back porch (≥1)
- H_DISP, 800, active pixels per line; must be a multiple of 8
- H_FRONT, 40, horizontal front porch (≥1)
- V_SYNC, 2, VS pulse width in lines (≥1)
- V_BACK, 33, vertical back porch (≥1)
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch (≥1)
- HS_POL, 0, 1 = HS active high, 0 = active low
- VS_POL, 0, 1 = VS active high, 0 = active low
- LEAD, 1, request-to-DE latency in cycles, 1..8
- BL_FRAMES, 2, complete frames after reset before backlight turns on (0 = immediately)
- CNT_W, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be < 2^CNT_W

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- pattern_en, in, 1, 1 = output internal colour bars instead of pixel_data
- pixel_data, in, 16, RGB565 from upstream, valid LEAD-1 cycles after its request (LEAD=1: same cycle)
- pixel_req, out, 1, request strobe; pixel_xpos/ypos are valid while high
- pixel_xpos, out, CNT_W, requested column 0..H_DISP-1 (0 when pixel_req low)
- pixel_ypos, out, CNT_W, requested row 0..V_DISP-1 (0 when pixel_req low)
- frame_start, out, 1, one-cycle pulse at h_cnt=0, v_cnt=0 (request domain)
- lcd_de, out, 1, data enable
- lcd_hs, out, 1, horizontal sync
- lcd_vs, out, 1, vertical sync
- lcd_bl, out, 1, backlight enable
- lcd_rst, out, 1, panel reset (active low)
- lcd_rgb_data, out, 16, RGB565 pixel data

Behaviour:
- Timing totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL defined likewise.
- Counters: h_cnt counts 0..H_TOTAL-1 then wraps to 0. v_cnt increments on each h_cnt wrap and wraps to 0 after V_TOTAL-1.
- Request domain (combinational from the counters):
  - hs_i = h_cnt < H_SYNC; vs_i = v_cnt < V_SYNC.
  - act = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
  - pixel_req = act; pixel_xpos = h_cnt-(H_SYNC+H_BACK); pixel_ypos = v_cnt-(V_SYNC+V_BACK).
- Output alignment: a delay line of depth LEAD carries {act, hs_i, vs_i}.
  - lcd_de, lcd_hs and lcd_vs are registered LEAD cycles after the request domain.
  - lcd_hs = hs_d ^ ~HS_POL; lcd_vs = vs_d ^ ~VS_POL.
  - lcd_rgb_data is registered in the same cycle as lcd_de. It takes the selected source when the delayed act is high, otherwise 0x0000.
- Pattern mode:
  - pattern_en is sampled only on frame_start, so a mid-frame change takes effect at the next frame.
  - Bars are H_DISP/8 pixels wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - The bar index comes from a width counter, not a divider. The pattern source is pipelined so it aligns with lcd_de exactly like pixel_data.
- Backlight:
  - frame counter saturates at BL_FRAMES and increments at each v_cnt wrap.
  - lcd_bl = 1 once count == BL_FRAMES; registered.
- lcd_rst: registered; 0 in reset, 1 from the first clock edge after rst_n deasserts.
- Reset values (rst_n low, any time, including mid-frame):
  - counters and delay line = 0.
  - pixel_req = 0, frame_start = 0, lcd_de = 0, lcd_rgb_data = 0.
  - lcd_hs and lcd_vs at their inactive levels.
  - lcd_bl = 0, lcd_rst = 0, sampled pattern mode = 0.
- Restart: after reset release, h_cnt=0 and v_cnt=0 in the first cycle, so frame_start pulses in the first cycle.
- Simultaneous events: an h wrap and a v wrap in the same cycle advance the frame counter once. frame_start and the pattern sample coincide.

Decomposition:
- Package lcd_timing_pkg holds:
  - RGB565 colour constants.
  - Timing presets for 800x480 and 480x272 panels.
  - The LEAD maximum constant.
- One sub-module, lcd_color_bar: x-position/active in, RGB565 out, with internal bar counter.

Test Plan (small config: H=2/3/16/3 (H_TOTAL 24), V=1/2/4/1 (V_TOTAL 8), LEAD=2, polarities 0, BL_FRAMES=2):
- Reset release -> frame_start at cycle 0; lcd_hs low for h_cnt 0..1 after 2-cycle delay; lcd_vs low for the first 24+2 cycles; line period 24, frame period 192 cycles.
- v_cnt=3, h_cnt=5 -> pixel_req=1, xpos=0, ypos=0; lcd_de rises 2 cycles later; 16-cycle DE pulses on 4 lines per frame.
- Upstream returns pixel_data = {ypos[7:0], xpos[7:0]} 1 cycle after request -> lcd_rgb_data = 0x0000..0x000F on line 0 aligned with DE; 0 outside DE.
- pattern_en raised mid-frame -> no change until next frame_start; then each 2-pixel group outputs FFFF, FFE0, …, 0000.
- Count frames -> lcd_bl low for cycles 0..383 and high from cycle 384 onward; lcd_rst high from cycle 1.
- rst_n pulsed low mid-active-line -> all outputs immediately at reset values (hs/vs high); timing restarts from frame_start; lcd_bl low again for 2 frames.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared colours, panel presets and limits for the LCD timing generator
package lcd_timing_pkg;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  localparam int LEAD_MAX = 8;

  localparam int P800_H_SYNC  = 128;
  localparam int P800_H_BACK  = 88;
  localparam int P800_H_DISP  = 800;
  localparam int P800_H_FRONT = 40;
  localparam int P800_V_SYNC  = 2;
  localparam int P800_V_BACK  = 33;
  localparam int P800_V_DISP  = 480;
  localparam int P800_V_FRONT = 10;

  localparam int P480_H_SYNC  = 41;
  localparam int P480_H_BACK  = 2;
  localparam int P480_H_DISP  = 480;
  localparam int P480_H_FRONT = 2;
  localparam int P480_V_SYNC  = 10;
  localparam int P480_V_BACK  = 2;
  localparam int P480_V_DISP  = 272;
  localparam int P480_V_FRONT = 2;

  // Bar order, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_color_bar.sv
// rtl/lcd_color_bar.sv - eight vertical colour bars; position tracked by a width counter
module lcd_color_bar
  import lcd_timing_pkg::*;
#(
  parameter int H_DISP = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_act,
  output logic [15:0] o_rgb
);

  localparam int BAR_W = H_DISP / 8;
  localparam int WC_W  = $clog2(BAR_W + 1);
  localparam logic [WC_W-1:0] W_LAST = WC_W'(BAR_W - 1);

  logic [WC_W-1:0] r_wcnt;
  logic [2:0]      r_bar;

  // Counters sit at zero through blanking so every line restarts at the first bar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_bar  <= '0;
    end else if (!i_act) begin
      r_wcnt <= '0;
      r_bar  <= '0;
    end else if (r_wcnt == W_LAST) begin
      r_wcnt <= '0;
      r_bar  <= r_bar + 3'd1;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign o_rgb = bar_color(r_bar);

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised RGB LCD timing with lead-time pixel requests and test bars
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int H_DISP    = 800,
  parameter int H_FRONT   = 40,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_DISP    = 480,
  parameter int V_FRONT   = 10,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int LEAD      = 1,
  parameter int BL_FRAMES = 2,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pattern_en,
  input  logic [15:0]      pixel_data,
  output logic             pixel_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             frame_start,
  output logic             lcd_de,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_bl,
  output logic             lcd_rst,
  output logic [15:0]      lcd_rgb_data
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_A0   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_A1   = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_A0   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_A1   = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  localparam int FW = $clog2(BL_FRAMES + 2);
  localparam logic [FW-1:0] BL_MAX = FW'(BL_FRAMES);

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_h_wrap, w_v_wrap;
  logic             w_hs_i, w_vs_i, w_act, w_act_pre;
  logic [2:0]       r_dly [1:LEAD];
  logic [2:0]       w_tap [0:LEAD];
  logic [15:0]      w_bar_rgb, w_src, r_rgb;
  logic             r_pat_mode, r_bl, r_lcd_rst;
  logic [FW-1:0]    r_frames, w_frames_nxt;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end
  end

  assign w_hs_i = (r_h_cnt < H_SW);
  assign w_vs_i = (r_v_cnt < V_SW);
  assign w_act  = (r_h_cnt >= H_A0) && (r_h_cnt < H_A1) &&
                  (r_v_cnt >= V_A0) && (r_v_cnt < V_A1);

  assign pixel_req   = w_act;
  assign pixel_xpos  = w_act ? r_h_cnt - H_A0 : '0;
  assign pixel_ypos  = w_act ? r_v_cnt - V_A0 : '0;
  // Counters rest at 0 during reset, so the pulse must be masked by rst_n itself.
  assign frame_start = rst_n && (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_tap[0] = {w_act, w_hs_i, w_vs_i};
  for (genvar k = 1; k <= LEAD; k++) begin : g_tap
    assign w_tap[k] = r_dly[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LEAD; k++) r_dly[k] <= '0;
    end else begin
      for (int k = 1; k <= LEAD; k++) r_dly[k] <= w_tap[k-1];
    end
  end

  // Active flag one stage before the pins: the cycle in which pixel_data is valid.
  assign w_act_pre = w_tap[LEAD-1][2];

  lcd_color_bar #(.H_DISP(H_DISP)) u_color_bar (
    .clk   (clk),
    .rst_n (rst_n),
    .i_act (w_act_pre),
    .o_rgb (w_bar_rgb)
  );

  assign w_src = r_pat_mode ? w_bar_rgb : pixel_data;
  assign w_frames_nxt = (w_v_wrap && (r_frames != BL_MAX)) ? r_frames + 1'b1 : r_frames;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb      <= '0;
      r_pat_mode <= 1'b0;
      r_frames   <= '0;
      r_bl       <= 1'b0;
      r_lcd_rst  <= 1'b0;
    end else begin
      r_rgb     <= w_act_pre ? w_src : 16'h0000;
      if (frame_start) r_pat_mode <= pattern_en;
      r_frames  <= w_frames_nxt;
      r_bl      <= (w_frames_nxt == BL_MAX);
      r_lcd_rst <= 1'b1;
    end
  end

  assign lcd_de       = r_dly[LEAD][2];
  assign lcd_hs       = r_dly[LEAD][1] ^ ~HS_ACT;
  assign lcd_vs       = r_dly[LEAD][0] ^ ~VS_ACT;
  assign lcd_rgb_data = r_rgb;
  assign lcd_bl       = r_bl;
  assign lcd_rst      = r_lcd_rst;

endmodule
